// File: rtl/sync_updown_mod_counter.sv
// rtl/sync_updown_mod_counter.sv - fully synchronous up/down modulo counter with load, saturate and cascade outputs
module sync_updown_mod_counter #(
    parameter int     WIDTH    = 4,
    parameter longint MOD      = 16,
    parameter int     SATURATE = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP,
    output logic             LDERR
);

    // Full binary span of the counter register; MOD may use all of it.
    localparam longint SPAN = longint'(1) << WIDTH;

    // Largest legal count; also the clamp target for out-of-range loads.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

    // A load can only exceed the range when MOD leaves codes unused.
    localparam bit CLAMP_POSSIBLE = (MOD < SPAN);

    // Reject illegal parameter combinations at elaboration.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("sync_updown_mod_counter: WIDTH must be 1..32");
        end
        if (MOD < 2 || MOD > SPAN) begin : g_bad_mod
            $error("sync_updown_mod_counter: MOD must be 2..2**WIDTH");
        end
        if (SATURATE != 0 && SATURATE != 1) begin : g_bad_sat
            $error("sync_updown_mod_counter: SATURATE must be 0 or 1");
        end
    endgenerate

    logic             at_max;
    logic             at_zero;
    logic             terminal;
    logic             load_oor;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             lderr_next;

    // Terminal value depends on direction, which is sampled every cycle.
    assign at_max   = (Q == MAX_Q);
    assign at_zero  = (Q == '0);
    assign terminal = UP ? at_max : at_zero;
    assign load_oor = CLAMP_POSSIBLE && (D > MAX_Q);

    // Terminal count is combinational so the next stage steps on the same edge.
    assign TC = EN & terminal;

    // Next-state selection: LOAD beats EN; otherwise hold with pulses cleared.
    always_comb begin
        q_next     = Q;
        wrap_next  = 1'b0;
        lderr_next = 1'b0;
        if (LOAD) begin
            if (load_oor) begin
                q_next     = MAX_Q;
                lderr_next = 1'b1;
            end else begin
                q_next = D;
            end
        end else if (EN) begin
            if (terminal) begin
                if (SATURATE == 0) begin
                    q_next    = UP ? '0 : MAX_Q;
                    wrap_next = 1'b1;
                end
            end else begin
                q_next = UP ? Q + 1'b1 : Q - 1'b1;
            end
        end
    end

    // State register; reset overrides load and count on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q     <= '0;
            WRAP  <= 1'b0;
            LDERR <= 1'b0;
        end else begin
            Q     <= q_next;
            WRAP  <= wrap_next;
            LDERR <= lderr_next;
        end
    end

endmodule
